// File: rtl/csum_share_ctrl.sv
// csum_share_ctrl: round-robin scheduler sharing one cumulative-sum engine between NREQ requesters
// Ports:
//   clk_data, rst_n          : single clock, synchronous active-low reset
//   req, req_n, req_data     : per-requester job request, word count and data word (packed slices)
//   gnt                      : registered one-hot grant, held for the whole job
//   data_rdy                 : granted requester's word consumed this cycle
//   eng_start, eng_n         : one-cycle engine start pulse with word count
//   eng_data                 : data word to engine, valid while data_rdy
//   eng_done, eng_sum        : engine completion level and its sum
//   res_valid/id/sum/err     : result port (valid/ready), res_err marks engine timeout
//   res_ready                : consumer accepts result
//   busy                     : controller not idle
module csum_share_ctrl #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int NW   = 8,
    parameter int SW   = 16,
    parameter int TMO  = 15
) (
    input  logic                    clk_data,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NW-1:0]      req_n,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    data_rdy,
    output logic                    eng_start,
    output logic [NW-1:0]           eng_n,
    output logic [DW-1:0]           eng_data,
    input  logic                    eng_done,
    input  logic [SW-1:0]           eng_sum,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [SW-1:0]           res_sum,
    output logic                    res_err,
    input  logic                    res_ready,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, RESULT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr, id, win;
    logic [NW-1:0] n, cnt;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] idx;

    // walk the ring from the highest offset down so the nearest set bit at/after rr wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr) + k) % NREQ);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_n     = '0;
        data_rdy  = 1'b0;
        eng_data  = '0;
        res_valid = 1'b0;
        busy      = state != IDLE;
        unique case (state)
            IDLE:   if (|req) state_nxt = LOAD;
            LOAD: begin
                eng_start = 1'b1;
                eng_n     = n;
                state_nxt = (n == '0) ? RESULT : FEED;
            end
            FEED: begin
                data_rdy  = 1'b1;
                eng_data  = req_data[id*DW +: DW];
                state_nxt = (cnt == NW'(1)) ? WAIT : FEED;
            end
            WAIT:   if (eng_done || tcnt == TW'(TMO - 1)) state_nxt = RESULT;
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign res_id = id;

    always_ff @(posedge clk_data) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= '0;
            id      <= '0;
            n       <= '0;
            cnt     <= '0;
            tcnt    <= '0;
            gnt     <= '0;
            res_sum <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (|req) begin
                    id  <= win;
                    n   <= req_n[win*NW +: NW];
                    gnt <= NREQ'(1) << win;
                    rr  <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                // zero-length jobs reach RESULT straight from here with a clean zero result
                LOAD: begin
                    cnt     <= n;
                    res_sum <= '0;
                    res_err <= 1'b0;
                end
                FEED: begin
                    cnt  <= cnt - 1'b1;
                    tcnt <= '0;
                end
                // done takes priority over a timeout landing on the same cycle
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (eng_done) begin
                        res_sum <= eng_sum;
                        res_err <= 1'b0;
                    end else if (tcnt == TW'(TMO - 1)) begin
                        res_sum <= '0;
                        res_err <= 1'b1;
                    end
                end
                RESULT: if (res_ready) gnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csum_share_ctrl.sv
// tb_csum_share_ctrl: directed self-checking bench for csum_share_ctrl
module tb_csum_share_ctrl;
    localparam int NREQ = 4, DW = 8, NW = 8, SW = 16, TMO = 15;

    logic                 clk_data = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*NW-1:0]   req_n;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 data_rdy, eng_start;
    logic [NW-1:0]        eng_n;
    logic [DW-1:0]        eng_data;
    logic                 eng_done;
    logic [SW-1:0]        eng_sum;
    logic                 res_valid;
    logic [1:0]           res_id;
    logic [SW-1:0]        res_sum;
    logic                 res_err, res_ready, busy;

    int total = 0;
    int bad   = 0;

    csum_share_ctrl #(.NREQ(NREQ), .DW(DW), .NW(NW), .SW(SW), .TMO(TMO)) dut (
        .clk_data(clk_data), .rst_n(rst_n), .req(req), .req_n(req_n), .req_data(req_data),
        .gnt(gnt), .data_rdy(data_rdy), .eng_start(eng_start), .eng_n(eng_n), .eng_data(eng_data),
        .eng_done(eng_done), .eng_sum(eng_sum), .res_valid(res_valid), .res_id(res_id),
        .res_sum(res_sum), .res_err(res_err), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk_data = ~clk_data;

    task automatic tick();
        @(negedge clk_data);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int feed, waits;
        rst_n = 1'b0; req = '0; req_n = '0; req_data = '0;
        eng_done = 1'b0; eng_sum = '0; res_ready = 1'b0;
        tick(); tick();
        chk("reset_outputs", {gnt, data_rdy, eng_start, eng_n, eng_data, res_valid, res_id, res_sum, res_err, busy}, '0);
        rst_n = 1'b1;

        // single job: requester 0, N=3, data 5,6,7, sum 18
        req = 4'b0001; req_n[0 +: NW] = 8'd3; req_data[0 +: DW] = 8'd5;
        tick();
        chk("t1_load", {gnt, eng_start, eng_n, busy, data_rdy}, {4'b0001, 1'b1, 8'd3, 1'b1, 1'b0});
        req = '0;
        tick();
        chk("t1_w1", {data_rdy, eng_start, eng_data}, {1'b1, 1'b0, 8'd5});
        req_data[0 +: DW] = 8'd6;
        tick();
        chk("t1_w2", {data_rdy, eng_data}, {1'b1, 8'd6});
        req_data[0 +: DW] = 8'd7;
        tick();
        chk("t1_w3", {data_rdy, eng_data}, {1'b1, 8'd7});
        tick();
        chk("t1_wait1", {data_rdy, eng_start, res_valid, busy}, {1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        eng_done = 1'b1; eng_sum = 16'd18;
        tick();
        chk("t1_result", {res_valid, res_id, res_sum, res_err, gnt}, {1'b1, 2'd0, 16'd18, 1'b0, 4'b0001});
        eng_done = 1'b0; res_ready = 1'b1;
        tick();
        chk("t1_idle", {res_valid, gnt, busy}, '0);
        res_ready = 1'b0;

        // round robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111; req_n = {4{8'd1}}; res_ready = 1'b1; eng_done = 1'b1; eng_sum = 16'h55;
        for (int j = 0; j < 5; j++) begin
            for (int t = 0; t < 10 && !eng_start; t++) tick();
            chk($sformatf("rr_start%0d", j), eng_start, 1'b1);
            chk($sformatf("rr_gnt%0d", j), gnt, 4'b0001 << (j % 4));
            for (int t = 0; t < 10 && !res_valid; t++) tick();
            chk($sformatf("rr_res%0d", j), {res_valid, res_id, res_sum, gnt}, {1'b1, 2'(j % 4), 16'h55, 4'b0001 << (j % 4)});
            if (j == 4) req = '0;
            tick();
        end
        res_ready = 1'b0;

        // zero-length job on requester 2; engine done must be ignored
        req = 4'b0100; req_n[2*NW +: NW] = 8'd0; eng_done = 1'b1; eng_sum = 16'hABCD;
        tick();
        chk("t3_load", {gnt, eng_start, eng_n, data_rdy}, {4'b0100, 1'b1, 8'd0, 1'b0});
        req = '0;
        tick();
        chk("t3_result", {res_valid, res_id, res_sum, res_err, data_rdy}, {1'b1, 2'd2, 16'd0, 1'b0, 1'b0});
        res_ready = 1'b1; eng_done = 1'b0;
        tick();
        chk("t3_idle", {res_valid, busy}, '0);
        res_ready = 1'b0;

        // timeout on requester 1, N=2
        req = 4'b0010; req_n[1*NW +: NW] = 8'd2;
        tick();
        chk("t4_load", {gnt, eng_start, eng_n}, {4'b0010, 1'b1, 8'd2});
        req = '0;
        feed = 0; waits = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (res_valid) break;
            if (data_rdy) feed++;
            else waits++;
        end
        chk("t4_feed_cycles", feed, 2);
        chk("t4_wait_cycles", waits, TMO);
        chk("t4_result", {res_valid, res_id, res_sum, res_err}, {1'b1, 2'd1, 16'd0, 1'b1});

        // backpressure: result held while every requester asks
        req = 4'b1111; req_n = {4{8'd4}};
        for (int t = 0; t < 10; t++) begin
            tick();
            chk($sformatf("bp_hold%0d", t), {res_valid, res_err, res_id, res_sum, gnt, eng_start, busy},
                {1'b1, 1'b1, 2'd1, 16'd0, 4'b0010, 1'b0, 1'b1});
        end
        res_ready = 1'b1;
        tick();
        chk("bp_idle_gap", {gnt, busy, res_valid, eng_start}, '0);
        res_ready = 1'b0; req_data[2*DW +: DW] = 8'h21;
        tick();
        chk("bp_next_grant", {gnt, eng_start, eng_n}, {4'b0100, 1'b1, 8'd4});

        // reset during the second of four words
        tick();
        chk("t6_w1", {data_rdy, eng_data}, {1'b1, 8'h21});
        req_data[2*DW +: DW] = 8'h22;
        tick();
        chk("t6_w2", {data_rdy, eng_data}, {1'b1, 8'h22});
        rst_n = 1'b0;
        tick();
        chk("t6_reset", {gnt, data_rdy, eng_start, eng_n, eng_data, res_valid, res_id, res_sum, res_err, busy}, '0);
        rst_n = 1'b1; req = 4'b1000;
        tick();
        chk("t6_regrant", {gnt, eng_start, eng_n}, {4'b1000, 1'b1, 8'd4});
        req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csum_share_ctrl.md
Name: csum_share_ctrl

Overview:
- Round-robin scheduler that shares one cumulative-sum accumulator engine between NREQ requesters.
- Per job it picks a requester, starts the engine with that requester's word count N, and streams N data words from it.
- It then waits for engine done and holds the sum, tagged with the requester id, on a valid/ready result port.
- Sits between requester clients and the single accumulator datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data word width
NW, 8, word-count width
SW, 16, sum width
TMO, 15, max cycles in WAIT before declaring engine timeout

Ports:
clk_data  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  NREQ  job request per requester, level
req_n  in  NREQ*NW  word count, requester i at [i*NW +: NW]
req_data  in  NREQ*DW  data word, requester i at [i*DW +: DW]
gnt  out  NREQ  one-hot grant, held for whole job
data_rdy  out  1  high = granted requester's word consumed this cycle
eng_start  out  1  one-cycle engine start pulse
eng_n  out  NW  word count to engine, valid with eng_start
eng_data  out  DW  data word to engine, valid while data_rdy
eng_done  in  1  engine finished, level
eng_sum  in  SW  engine sum, valid while eng_done
res_valid  out  1  result available
res_id  out  $clog2(NREQ)  requester index of result
res_sum  out  SW  captured sum
res_err  out  1  result is a timeout (res_sum forced 0)
res_ready  in  1  consumer accepts result
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock clk_data; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clock edge): state=IDLE, rr pointer=0, gnt=0, data_rdy=0, eng_start=0, eng_n=0, eng_data=0, res_valid=0, res_id=0, res_sum=0, res_err=0, busy=0, counters=0. Reset mid-job aborts immediately; no result is emitted.
- States: IDLE, LOAD, FEED, WAIT, RESULT.
- IDLE:
  - If any req bit is set, grant the first set bit at or above rr pointer, searching cyclically.
  - Latch winner id and req_n, then go to LOAD; gnt is registered (asserts the cycle the FSM enters LOAD).
  - rr pointer := winner+1 mod NREQ.
- LOAD:
  - eng_start=1 for exactly this cycle; eng_n=latched N; remaining counter := N.
  - If N==0: skip engine, go to RESULT with res_sum=0, res_err=0.
  - Otherwise go to FEED.
- FEED:
  - data_rdy=1; eng_data=winner's req_data slice (combinational mux on latched id).
  - Counter decrements each cycle; after exactly N FEED cycles go to WAIT.
  - Requester must present a new word every cycle while data_rdy is high.
  - Changes to req/req_n of any requester are ignored until IDLE.
- WAIT:
  - Timeout counter starts at 0 and increments each cycle.
  - On eng_done=1: capture eng_sum into res_sum, res_err=0, go to RESULT.
  - If counter reaches TMO with no done: res_sum=0, res_err=1, go to RESULT.
  - done and timeout on the same cycle: done wins.
- RESULT:
  - res_valid=1; res_id, res_sum and res_err are held stable.
  - On res_ready=1: clear res_valid and gnt, go to IDLE. Earliest next grant is the following cycle.
  - gnt stays asserted through RESULT.
- Minimum job latency from req to res_valid: N+3 cycles plus engine done delay.
- Max N = 2^NW-1; no arbitration overhead is added per word.
- Arithmetic: the controller does no summation; eng_sum is passed through unmodified at SW bits.

Test Plan:
- Single job: req=0001, N0=3, data 5,6,7, eng_done 2 cycles after FEED with sum 18 -> eng_start one pulse with eng_n=3, data_rdy high exactly 3 cycles, res_valid with res_id=0, res_sum=18, res_err=0.
- Round robin: req=1111 held, res_ready=1 always -> grants in order 0,1,2,3,0; each gnt one-hot and never overlapping.
- N=0: req=0100, N2=0 -> eng_start pulses once, no data_rdy, res_valid with res_id=2, res_sum=0, res_err=0, engine done ignored.
- Timeout: req=0010, N1=2, eng_done held 0 -> after 2 FEED cycles plus TMO(15) WAIT cycles, res_valid with res_err=1, res_sum=0.
- Backpressure: result pending with res_ready=0 for 10 cycles while req=1111 -> res_* stable, gnt unchanged, no new eng_start; res_ready=1 -> next grant after one IDLE cycle.
- Reset mid-FEED: rst_n=0 during word 2 of 4 -> next cycle all outputs 0 and state IDLE; after release, req=1000 -> grant 3 (pointer back at 0, first set bit).
